// File: rtl/obuf_pkg.sv
// obuf_pkg: shared definitions for the output-buffer arbiter.
//   - default row width / row count for obuf_arb
//   - drain controller state encoding
package obuf_pkg;

  localparam int VEC_WIDTH_DEF = 64;  // INT4 x 16 per row
  localparam int ARR_DEPTH_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } obuf_state_e;

endpackage

// File: rtl/obuf_skid.sv
// obuf_skid: 2-entry FIFO that absorbs RAM read returns while the
// consumer is stalled.
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_push/i_data  write side (ignored when full)
//   i_pop          pop request (ignored when empty)
//   o_valid/o_data head entry
//   o_count        current occupancy (0..2)
module obuf_skid #(
  parameter int W = 70
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = i_pop && (count_q != 2'd0);
  assign do_push = i_push && (count_q != 2'd2);

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign o_valid = (count_q != 2'd0);
  assign o_data  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/obuf_arb.sv
// obuf_arb: arbitrates a single external RAM port between PPU row writes
// (absolute priority) and an in-order drain that streams every written row
// out through a ready/valid interface.
//   i_clk, i_rst                    clock, synchronous active-high reset
//   i_ppu_we/addr/data              PPU row write
//   i_drain_start                   start a drain (honoured in IDLE only)
//   o_ram_we/addr/data, i_ram_q     external RAM port, 1-cycle read latency
//   o_rd_valid/addr/data, i_rd_ready drain stream
//   o_drain_busy, o_drain_done      drain status, done is a 1-cycle pulse
//   o_ovw_err                       sticky: a not-yet-drained row was rewritten
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for i_drain_start
// ST_DRAIN | reading rows 0..ARR_DEPTH-1 in order, stalling on unwritten rows
// ST_FLUSH | all reads issued, waiting for the skid FIFO and RAM to empty
module obuf_arb
  import obuf_pkg::*;
#(
  parameter  int VEC_WIDTH = VEC_WIDTH_DEF,
  parameter  int ARR_DEPTH = ARR_DEPTH_DEF,
  localparam int AW        = $clog2(ARR_DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ppu_we,
  input  logic [AW-1:0]        i_ppu_addr,
  input  logic [VEC_WIDTH-1:0] i_ppu_data,
  input  logic                 i_drain_start,
  output logic                 o_ram_we,
  output logic [AW-1:0]        o_ram_addr,
  output logic [VEC_WIDTH-1:0] o_ram_data,
  input  logic [VEC_WIDTH-1:0] i_ram_q,
  output logic                 o_rd_valid,
  output logic [AW-1:0]        o_rd_addr,
  output logic [VEC_WIDTH-1:0] o_rd_data,
  input  logic                 i_rd_ready,
  output logic                 o_drain_busy,
  output logic                 o_drain_done,
  output logic                 o_ovw_err
);

  obuf_state_e          state_q, state_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [ARR_DEPTH-1:0] bitmap_q, bitmap_d;
  logic                 inflight_q;
  logic [AW-1:0]        inflight_addr_q;
  logic                 ovw_err_q;

  logic                 skid_valid;
  logic [1:0]           skid_count;
  logic [AW+VEC_WIDTH-1:0] skid_head;
  logic                 pop;
  logic [1:0]           occ_after;
  logic                 issue;
  logic                 last_row;
  logic                 flush_done;

  assign pop = skid_valid & i_rd_ready & ~i_rst;

  // Occupancy is taken after this cycle's pop so a steady stream can issue
  // one read per cycle; a read issued here lands next cycle into a FIFO that
  // then holds at most one entry, so the 2-entry skid can never overflow.
  assign occ_after  = skid_count - {1'b0, pop} + {1'b0, inflight_q};
  assign issue      = (state_q == ST_DRAIN) & ~i_ppu_we & bitmap_q[rd_ptr_q] &
                      (occ_after < 2'd2);
  assign last_row   = (rd_ptr_q == AW'(ARR_DEPTH - 1));
  assign flush_done = (state_q == ST_FLUSH) & (skid_count == 2'd0) & ~inflight_q;

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    bitmap_d = bitmap_q;
    // Write and issue are mutually exclusive in a cycle, so the set and the
    // clear never collide.
    if (i_ppu_we) bitmap_d[i_ppu_addr] = 1'b1;
    if (issue) begin
      bitmap_d[rd_ptr_q] = 1'b0;
      rd_ptr_d = last_row ? '0 : rd_ptr_q + AW'(1);
    end
    case (state_q)
      ST_IDLE: begin
        if (i_drain_start) begin
          state_d  = ST_DRAIN;
          rd_ptr_d = '0;
        end
      end
      ST_DRAIN: if (issue && last_row) state_d = ST_FLUSH;
      ST_FLUSH: if (flush_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q         <= ST_IDLE;
      rd_ptr_q        <= '0;
      bitmap_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      ovw_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      rd_ptr_q        <= rd_ptr_d;
      bitmap_q        <= bitmap_d;
      inflight_q      <= issue;
      inflight_addr_q <= rd_ptr_q;
      ovw_err_q       <= ovw_err_q | (i_ppu_we & bitmap_q[i_ppu_addr]);
    end
  end

  // The skid's own reset drops any return that lands on the reset edge.
  obuf_skid #(.W(AW + VEC_WIDTH)) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (inflight_q),
    .i_data  ({inflight_addr_q, i_ram_q}),
    .i_pop   (pop),
    .o_valid (skid_valid),
    .o_data  (skid_head),
    .o_count (skid_count)
  );

  assign o_ram_we   = i_ppu_we;
  assign o_ram_addr = i_ppu_we ? i_ppu_addr : rd_ptr_q;
  assign o_ram_data = i_ppu_we ? i_ppu_data : '0;

  assign o_rd_valid   = skid_valid & ~i_rst;
  assign o_rd_addr    = skid_head[AW+VEC_WIDTH-1 -: AW];
  assign o_rd_data    = skid_head[VEC_WIDTH-1:0];
  assign o_drain_busy = (state_q != ST_IDLE) & ~i_rst;
  assign o_drain_done = flush_done & ~i_rst;
  assign o_ovw_err    = ovw_err_q;

endmodule
